gshare_predictor: RTL and testbench

- Parametrised successor to the single-pattern global-history branch predictor.
- Replaces the 16-bit one-bit pattern table with a gshare pattern history table (PHT) of 2-bit saturating counters.
  - PHT index is PC bits XOR the global history.
  - Global history register (GHR) is speculative, with checkpoint recovery on mispredict.
- Sits beside fetch: predicts in the fetch cycle and is trained from branch resolution (execute stage) through a separate update port.
- Keeps saturating performance counters for branches and mispredicts.

---
 rtl/gshare_predictor_pkg.sv | 26 ++
 rtl/gshare_predictor_if.sv | 37 +++
 rtl/gshare_predictor_sat_counter.sv | 37 +++
 rtl/gshare_predictor.sv | 86 ++++++++
 tb/tb_gshare_predictor.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/gshare_predictor_pkg.sv
// Shared branch-prediction definitions: branch opcode, 2-bit counter
// encodings and the saturating counter-update rule used by the PHT.
package gshare_predictor_pkg;

   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_e;

   function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
      logic [1:0] nxt;
      case (ctr)
         SNT:     nxt = taken ? WNT : SNT;
         WNT:     nxt = taken ? WT  : SNT;
         WT:      nxt = taken ? ST  : WNT;
         ST:      nxt = taken ? ST  : WT;
         default: nxt = ctr;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/gshare_predictor_if.sv
// Fetch, prediction, training and performance signals of the gshare predictor.
// The master drives fetch/update; the slave is the predictor itself.
interface gshare_predictor_if #(
   parameter int HIST_LEN = 8,
   parameter int IDX_BITS = 8,
   parameter int PERF_W   = 16
) ();

   logic                fetch_valid;
   logic [31:0]         fetch_instr;
   logic [31:0]         fetch_pc;
   logic                pred_taken;
   logic [IDX_BITS-1:0] pred_idx;
   logic [HIST_LEN-1:0] pred_ghr;
   logic                upd_valid;
   logic [IDX_BITS-1:0] upd_idx;
   logic                upd_taken;
   logic                upd_mispredict;
   logic [HIST_LEN-1:0] upd_ghr;
   logic [PERF_W-1:0]   perf_branches;
   logic [PERF_W-1:0]   perf_mispredicts;

   modport master (
      output fetch_valid, fetch_instr, fetch_pc,
      output upd_valid, upd_idx, upd_taken, upd_mispredict, upd_ghr,
      input  pred_taken, pred_idx, pred_ghr,
      input  perf_branches, perf_mispredicts
   );

   modport slave (
      input  fetch_valid, fetch_instr, fetch_pc,
      input  upd_valid, upd_idx, upd_taken, upd_mispredict, upd_ghr,
      output pred_taken, pred_idx, pred_ghr,
      output perf_branches, perf_mispredicts
   );

endinterface

// File: rtl/gshare_predictor_sat_counter.sv
// Saturating up/down counter; simultaneous inc and dec hold the value.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc,
   input  logic             dec,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_r;
   logic             at_max_s;
   logic             at_min_s;

   // saturation limits
   always_comb begin
      at_max_s = (count_r == {WIDTH{1'b1}});
      at_min_s = (count_r == {WIDTH{1'b0}});
   end

   // counter state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_r <= {WIDTH{1'b0}};
      end else if (inc && !dec && !at_max_s) begin
         count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
      end else if (dec && !inc && !at_min_s) begin
         count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/gshare_predictor.sv
// Gshare branch predictor: PC^GHR indexed 2-bit PHT, speculative global
// history with checkpoint recovery, and saturating performance counters.
module gshare_predictor
   import gshare_predictor_pkg::*;
#(
   parameter int         HIST_LEN = 8,
   parameter int         IDX_BITS = 8,
   parameter logic [1:0] CTR_INIT = 2'b10,
   parameter int         PERF_W   = 16
) (
   input logic               clk,
   input logic               reset_n,
   gshare_predictor_if.slave bus
);

   localparam int PHT_SIZE = 1 << IDX_BITS;

   logic [1:0]          pht_r [PHT_SIZE];
   logic [HIST_LEN-1:0] ghr_r;
   logic                is_br_s;
   logic [IDX_BITS-1:0] ghr_ext_s;
   logic [IDX_BITS-1:0] idx_s;
   logic                pred_taken_s;
   logic                recover_s;
   logic                mispredict_s;
   logic                unused_s;

   // zero-latency prediction; reads the PHT before any same-cycle training write
   always_comb begin
      is_br_s                  = bus.fetch_valid & (bus.fetch_instr[6:0] == OPC_BRANCH);
      ghr_ext_s                = {IDX_BITS{1'b0}};
      ghr_ext_s[HIST_LEN-1:0]  = ghr_r;
      idx_s                    = bus.fetch_pc[IDX_BITS+1:2] ^ ghr_ext_s;
      pred_taken_s             = is_br_s & pht_r[idx_s][1];
      mispredict_s             = bus.upd_valid & bus.upd_mispredict;
      recover_s                = mispredict_s;
   end

   assign bus.pred_taken = pred_taken_s;
   assign bus.pred_idx   = idx_s;
   assign bus.pred_ghr   = ghr_r;

   // global history: checkpoint recovery takes priority over the speculative shift
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ghr_r <= {HIST_LEN{1'b0}};
      end else if (recover_s) begin
         ghr_r <= {bus.upd_ghr[HIST_LEN-2:0], bus.upd_taken};
      end else if (is_br_s) begin
         ghr_r <= {ghr_r[HIST_LEN-2:0], pred_taken_s};
      end else begin
         ghr_r <= ghr_r;
      end
   end

   // pattern history table training from the resolution port
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < PHT_SIZE; i++) begin
            pht_r[i] <= CTR_INIT;
         end
      end else if (bus.upd_valid) begin
         pht_r[bus.upd_idx] <= ctr_update(pht_r[bus.upd_idx], bus.upd_taken);
      end
   end

   sat_counter #(.WIDTH(PERF_W)) u_perf_branches (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (bus.upd_valid),
      .dec     (1'b0),
      .count   (bus.perf_branches)
   );

   sat_counter #(.WIDTH(PERF_W)) u_perf_mispredicts (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (mispredict_s),
      .dec     (1'b0),
      .count   (bus.perf_mispredicts)
   );

   // instruction and PC bits outside the opcode/index fields do not affect prediction
   assign unused_s = ^{bus.fetch_instr[31:7], bus.fetch_pc[31:IDX_BITS+2], bus.fetch_pc[1:0]};

endmodule

// File: tb/tb_gshare_predictor.sv
// Scoreboard bench for gshare_predictor: stimulus pushes reference-model
// expectations, a negedge monitor pops and compares on every valid fetch.
module tb_gshare_predictor;

   localparam int HL   = 8;
   localparam int IB   = 8;
   localparam int PW   = 4;
   localparam int PMAX = (1 << PW) - 1;
   localparam int NENT = 1 << IB;

   typedef struct {
      logic          taken;
      logic [IB-1:0] idx;
      logic [HL-1:0] ghr;
      logic [PW-1:0] br;
      logic [PW-1:0] mp;
   } exp_t;

   logic clk;
   logic reset_n;

   gshare_predictor_if #(.HIST_LEN(HL), .IDX_BITS(IB), .PERF_W(PW)) bus ();

   gshare_predictor #(
      .HIST_LEN (HL),
      .IDX_BITS (IB),
      .CTR_INIT (2'b10),
      .PERF_W   (PW)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   exp_t q[$];
   int   total  = 0;
   int   passed = 0;

   // reference model state: counters as 0..3, history as plain integer
   int m_pht [NENT];
   int m_ghr;
   int m_nbr;
   int m_nmp;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      else passed++;
   endtask

   function automatic void model_reset();
      m_ghr = 0;
      m_nbr = 0;
      m_nmp = 0;
      for (int i = 0; i < NENT; i++) m_pht[i] = 2;
   endfunction

   function automatic void push_expect(input logic fv, input logic [31:0] instr, input logic [31:0] pc,
                                       output bit br, output bit pt);
      exp_t e;
      int   idx;
      br  = fv && (instr[6:0] == 7'h63);
      idx = ((pc >> 2) ^ m_ghr) % NENT;
      pt  = br && (m_pht[idx] >= 2);
      if (fv) begin
         e.taken = pt;
         e.idx   = IB'(idx);
         e.ghr   = HL'(m_ghr);
         e.br    = PW'(m_nbr);
         e.mp    = PW'(m_nmp);
         q.push_back(e);
      end
   endfunction

   task automatic drive(input logic fv, input logic [31:0] instr, input logic [31:0] pc,
                        input logic uv, input logic [7:0] uidx, input logic ut,
                        input logic um, input logic [7:0] ughr);
      bus.fetch_valid    = fv;
      bus.fetch_instr    = instr;
      bus.fetch_pc       = pc;
      bus.upd_valid      = uv;
      bus.upd_idx        = uidx;
      bus.upd_taken      = ut;
      bus.upd_mispredict = um;
      bus.upd_ghr        = ughr;
   endtask

   // one normal clock cycle: drive, record expectation, advance the model
   task automatic step(input logic fv, input logic [31:0] instr, input logic [31:0] pc,
                       input logic uv, input logic [7:0] uidx, input logic ut,
                       input logic um, input logic [7:0] ughr);
      bit br, pt;
      @(posedge clk); #1;
      reset_n = 1'b1;
      drive(fv, instr, pc, uv, uidx, ut, um, ughr);
      push_expect(fv, instr, pc, br, pt);
      if (uv && um) m_ghr = ((int'(ughr) << 1) | int'(ut)) % (1 << HL);
      else if (br)  m_ghr = ((m_ghr << 1) | int'(pt)) % (1 << HL);
      if (uv) begin
         if (ut) m_pht[uidx] = (m_pht[uidx] == 3) ? 3 : m_pht[uidx] + 1;
         else    m_pht[uidx] = (m_pht[uidx] == 0) ? 0 : m_pht[uidx] - 1;
         m_nbr = (m_nbr < PMAX) ? m_nbr + 1 : PMAX;
         if (um) m_nmp = (m_nmp < PMAX) ? m_nmp + 1 : PMAX;
      end
   endtask

   // reset asserted mid-cycle and held n cycles; each held cycle fetches a branch at index c
   task automatic do_reset(input int n);
      bit br, pt;
      for (int c = 0; c < n; c++) begin
         @(posedge clk); #1;
         if (c == 0) begin
            reset_n = 1'b0;
            model_reset();
         end
         drive(1'b1, {$urandom_range(0, 32'h1FFFFFF), 7'h63}, 32'(c) << 2, 1'($urandom),
               8'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
         push_expect(1'b1, bus.fetch_instr, bus.fetch_pc, br, pt);
      end
   endtask

   // monitor: compare every presented prediction against the oldest expectation
   always @(negedge clk) begin
      if (bus.fetch_valid === 1'b1) begin
         if (q.size() == 0) begin
            total++;
            $display("FAIL underflow: prediction presented with no expectation queued");
         end else begin
            exp_t e;
            e = q.pop_front();
            check("pred_taken", 32'(bus.pred_taken), 32'(e.taken));
            check("pred_idx", 32'(bus.pred_idx), 32'(e.idx));
            check("pred_ghr", 32'(bus.pred_ghr), 32'(e.ghr));
            check("perf_branches", 32'(bus.perf_branches), 32'(e.br));
            check("perf_mispredicts", 32'(bus.perf_mispredicts), 32'(e.mp));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] last_idx;
      reset_n = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      model_reset();
      repeat (2) @(posedge clk);

      // first branch after reset: weakly taken, index from PC only
      step(1'b1, 32'h0000_0063, 32'h100, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      check("beq_taken", 32'(bus.pred_taken), 32'h1);
      check("beq_idx", 32'(bus.pred_idx), 32'h40);
      check("beq_ghr", 32'(bus.pred_ghr), 32'h0);

      // three not-taken trainings drive 0x40 to strongly-not-taken
      step(1'b0, 32'h0, 32'h0, 1'b1, 8'h40, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      check("ghr_after_shift", 32'(bus.pred_ghr), 32'h1);
      repeat (2) step(1'b0, 32'h0, 32'h0, 1'b1, 8'h40, 1'b0, 1'b0, 8'h00);
      step(1'b1, 32'h0000_0063, 32'h104, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      check("snt_pred", 32'(bus.pred_taken), 32'h0);
      check("snt_idx", 32'(bus.pred_idx), 32'h40);
      step(1'b0, 32'h0, 32'h0, 1'b1, 8'h40, 1'b1, 1'b0, 8'h00);
      step(1'b1, 32'h0000_0063, 32'((8'h40 ^ 8'(m_ghr))) << 2, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      check("wnt_pred", 32'(bus.pred_taken), 32'h0);

      // non-branch leaves history alone
      step(1'b1, 32'h0000_0013, 32'h2468, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      check("nonbr_pred", 32'(bus.pred_taken), 32'h0);

      // recovery beats a same-cycle speculative shift
      step(1'b1, 32'h0000_0063, 32'h300, 1'b1, 8'h10, 1'b1, 1'b1, 8'h5A);
      step(1'b1, 32'h0000_0013, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      check("recover_ghr", 32'(bus.pred_ghr), 32'hB5);
      check("recover_mp", 32'(bus.perf_mispredicts), 32'h1);

      // same-cycle read/write of entry 0x40 (counter 01, trained taken)
      step(1'b1, 32'h0000_0063, 32'((8'h40 ^ 8'(m_ghr))) << 2, 1'b1, 8'h40, 1'b1, 1'b0, 8'h00);
      @(negedge clk);
      check("rw_same_cycle", 32'(bus.pred_taken), 32'h0);
      step(1'b1, 32'h0000_0063, 32'((8'h40 ^ 8'(m_ghr))) << 2, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      check("rw_next_cycle", 32'(bus.pred_taken), 32'h1);

      // perf counters saturate
      repeat (20) step(1'b0, 32'h0, 32'h0, 1'b1, 8'($urandom), 1'($urandom), 1'b1, 8'($urandom));
      step(1'b1, 32'h0000_0013, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      check("sat_branches", 32'(bus.perf_branches), 32'hF);
      check("sat_mispredicts", 32'(bus.perf_mispredicts), 32'hF);

      // mid-stream reset takes effect without a clock edge
      repeat (3) step(1'b0, 32'h0, 32'h0, 1'b1, 8'($urandom), 1'b1, 1'b1, 8'($urandom));
      do_reset(1);
      @(negedge clk);
      check("rst_branches", 32'(bus.perf_branches), 32'h0);
      check("rst_mispredicts", 32'(bus.perf_mispredicts), 32'h0);
      check("rst_ghr", 32'(bus.pred_ghr), 32'h0);
      check("rst_pred", 32'(bus.pred_taken), 32'h1);
      do_reset(NENT);

      // randomized traffic, with occasional resets
      last_idx = 8'h00;
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] instr;
         logic [31:0] pc;
         logic [7:0]  uidx;
         if (n % 700 == 699) do_reset(int'($urandom_range(1, 4)));
         instr = ($urandom_range(0, 3) != 0) ? {$urandom_range(0, 32'h1FFFFFF), 7'h63} : $urandom;
         pc    = {$urandom_range(0, 32'hFFF), 2'b00};
         uidx  = ($urandom_range(0, 1) == 1) ? last_idx : 8'($urandom);
         step(1'($urandom_range(0, 3) != 0), instr, pc, 1'($urandom), uidx,
              1'($urandom), 1'($urandom_range(0, 3) == 0), 8'($urandom));
         last_idx = bus.pred_idx;
      end

      @(posedge clk); #1;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      check("queue_drained", 32'(q.size()), 32'h0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
